// File: rtl/zeroriscy_lsu_ctrl_pkg.sv
// Shared encodings for the load/store controller: access types, FSM states
// and small decode helpers used by the top and the load aligner.
package zeroriscy_lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    DT_WORD = 2'b00,
    DT_HALF = 2'b01,
    DT_BYTE = 2'b10
  } data_type_e;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID,
    WAIT_GNT_MIS,
    WAIT_RVALID_MIS
  } lsu_state_e;

  // The unused 2'b11 encoding behaves as a word access.
  function automatic data_type_e decode_type(input logic [1:0] raw);
    case (raw)
      2'b01:   return DT_HALF;
      2'b10:   return DT_BYTE;
      default: return DT_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input data_type_e dtype, input logic [1:0] off);
    return ((dtype == DT_WORD) && (off != 2'd0)) || ((dtype == DT_HALF) && (off == 2'd3));
  endfunction

endpackage

// File: rtl/zeroriscy_lsu_rdata_align.sv
// Combinational load-data extraction: shifts the addressed bytes down to bit 0
// (joining both bus words for split accesses) and zero/sign-extends them.
module zeroriscy_lsu_rdata_align
  import zeroriscy_lsu_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [31:0] rdata_q,
  input  logic [1:0]  offset,
  input  data_type_e  data_type,
  input  logic        sign_ext,
  input  logic        misaligned,
  output logic [31:0] result
);

  logic [63:0] window;
  logic [4:0]  shamt;
  logic [31:0] word;

  always_comb begin
    shamt  = {offset, 3'b000};
    // Phase-1 word sits in the low half so the shift pulls phase-2 bytes in from above.
    window = misaligned ? {rdata, rdata_q} : {32'h0, rdata};
    word   = 32'(window >> shamt);
    case (data_type)
      DT_BYTE: result = {{24{sign_ext & word[7]}}, word[7:0]};
      DT_HALF: result = {{16{sign_ext & word[15]}}, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/zeroriscy_lsu_ctrl.sv
// Load/store controller: drives the OBI-style req/gnt/rvalid data bus, splits
// misaligned accesses into two transactions and returns extended load data.
module zeroriscy_lsu_ctrl
  import zeroriscy_lsu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req_ex_i,
  input  logic        data_we_ex_i,
  input  logic [1:0]  data_type_ex_i,
  input  logic        data_sign_ext_ex_i,
  input  logic [31:0] adder_result_ex_i,
  input  logic [31:0] data_wdata_ex_i,
  output logic [31:0] data_rdata_ex_o,
  output logic        lsu_ready_ex_o,
  output logic        busy_o,
  output logic        data_misaligned_o,
  output logic        load_err_o,
  output logic        store_err_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic        data_err_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic [31:0] data_rdata_i
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  data_type_e  type_q;
  logic        we_q, sign_q;

  logic        idle, bus_req, phase2, complete, capture, rdata_en;
  logic [31:0] cur_addr, cur_wdata, wdata_rot, align_result;
  data_type_e  cur_type;
  logic        cur_we, cur_mis;
  logic [1:0]  cur_off;
  logic [5:0]  rot_sh;
  logic [3:0]  be_base;
  logic [7:0]  be_wide;
  logic [29:0] word_addr_p2;

  // In IDLE the request is issued straight from the EX inputs; afterwards from the captured copy.
  assign idle      = (state_q == IDLE);
  assign cur_addr  = idle ? adder_result_ex_i : addr_q;
  assign cur_type  = idle ? decode_type(data_type_ex_i) : type_q;
  assign cur_we    = idle ? data_we_ex_i : we_q;
  assign cur_wdata = idle ? data_wdata_ex_i : wdata_q;
  assign cur_off   = cur_addr[1:0];
  assign cur_mis   = is_misaligned(cur_type, cur_off);
  assign phase2    = (state_q == WAIT_RVALID) || (state_q == WAIT_GNT_MIS);

  always_comb begin
    case (cur_type)
      DT_HALF: be_base = 4'b0011;
      DT_BYTE: be_base = 4'b0001;
      default: be_base = 4'b1111;
    endcase
    // Bytes shifted past lane 3 land in the upper nibble and become the phase-2 enables.
    be_wide      = {4'b0000, be_base} << cur_off;
    rot_sh       = {1'b0, cur_off, 3'b000};
    wdata_rot    = (cur_wdata << rot_sh) | (cur_wdata >> (6'd32 - rot_sh));
    word_addr_p2 = cur_addr[31:2] + 30'd1;
  end

  always_comb begin
    state_d  = state_q;
    bus_req  = 1'b0;
    complete = 1'b0;
    capture  = 1'b0;
    rdata_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_req_ex_i) begin
          bus_req = 1'b1;
          capture = 1'b1;
          state_d = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        bus_req = 1'b1;
        if (data_gnt_i) state_d = WAIT_RVALID;
      end
      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          if (cur_mis && !data_err_i) begin
            bus_req  = 1'b1;
            rdata_en = 1'b1;
            state_d  = data_gnt_i ? WAIT_RVALID_MIS : WAIT_GNT_MIS;
          end else begin
            complete = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      WAIT_GNT_MIS: begin
        bus_req = 1'b1;
        if (data_gnt_i) state_d = WAIT_RVALID_MIS;
      end
      WAIT_RVALID_MIS: begin
        if (data_rvalid_i) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      type_q  <= DT_WORD;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_q  <= adder_result_ex_i;
        wdata_q <= data_wdata_ex_i;
        type_q  <= decode_type(data_type_ex_i);
        we_q    <= data_we_ex_i;
        sign_q  <= data_sign_ext_ex_i;
      end
      if (rdata_en) rdata_q <= data_rdata_i;
    end
  end

  zeroriscy_lsu_rdata_align u_align (
    .rdata      (data_rdata_i),
    .rdata_q    (rdata_q),
    .offset     (addr_q[1:0]),
    .data_type  (type_q),
    .sign_ext   (sign_q),
    .misaligned (state_q == WAIT_RVALID_MIS),
    .result     (align_result)
  );

  assign data_req_o        = bus_req;
  assign data_addr_o       = bus_req ? (phase2 ? {word_addr_p2, 2'b00} : {cur_addr[31:2], 2'b00}) : 32'h0;
  assign data_be_o         = bus_req ? (phase2 ? be_wide[7:4] : be_wide[3:0]) : 4'b0000;
  assign data_we_o         = bus_req & cur_we;
  assign data_wdata_o      = bus_req ? wdata_rot : 32'h0;
  assign busy_o            = !idle;
  assign data_misaligned_o = idle ? (data_req_ex_i & cur_mis) : cur_mis;
  assign lsu_ready_ex_o    = (idle & !data_req_ex_i) | complete;
  assign load_err_o        = complete & data_err_i & !we_q;
  assign store_err_o       = complete & data_err_i & we_q;
  assign data_rdata_ex_o   = (complete && !we_q) ? align_result : 32'h0;

endmodule

// File: tb/tb_zeroriscy_lsu_ctrl.sv
// Scoreboard bench for zeroriscy_lsu_ctrl: a bus responder checks each beat,
// a monitor checks each completion against hand-computed expectations.
module tb_zeroriscy_lsu_ctrl;

  logic        clk, rst_n;
  logic        data_req_ex_i, data_we_ex_i, data_sign_ext_ex_i;
  logic [1:0]  data_type_ex_i;
  logic [31:0] adder_result_ex_i, data_wdata_ex_i, data_rdata_ex_o;
  logic        lsu_ready_ex_o, busy_o, data_misaligned_o, load_err_o, store_err_o;
  logic        data_req_o, data_gnt_i, data_rvalid_i, data_err_i, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]  data_be_o;

  zeroriscy_lsu_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .data_req_ex_i      (data_req_ex_i),
    .data_we_ex_i       (data_we_ex_i),
    .data_type_ex_i     (data_type_ex_i),
    .data_sign_ext_ex_i (data_sign_ext_ex_i),
    .adder_result_ex_i  (adder_result_ex_i),
    .data_wdata_ex_i    (data_wdata_ex_i),
    .data_rdata_ex_o    (data_rdata_ex_o),
    .lsu_ready_ex_o     (lsu_ready_ex_o),
    .busy_o             (busy_o),
    .data_misaligned_o  (data_misaligned_o),
    .load_err_o         (load_err_o),
    .store_err_o        (store_err_o),
    .data_req_o         (data_req_o),
    .data_gnt_i         (data_gnt_i),
    .data_rvalid_i      (data_rvalid_i),
    .data_err_i         (data_err_i),
    .data_addr_o        (data_addr_o),
    .data_we_o          (data_we_o),
    .data_be_o          (data_be_o),
    .data_wdata_o       (data_wdata_o),
    .data_rdata_i       (data_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic        is_load;
    logic        chk_data;
    logic [31:0] rdata;
    logic        err;
    logic        mis;
  } done_t;

  beat_t       exp_beats[$];
  done_t       exp_done[$];
  logic [31:0] rsp_data[$];
  logic        rsp_err[$];
  int          gnt_dly = 0;
  int          rv_dly = 0;
  int          grant_count = 0;
  int          n_vec = 0;
  int          n_fail = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pushBeat(input logic [31:0] addr, input logic [3:0] be, input logic we,
                          input logic [31:0] wdata);
    beat_t b;
    b.addr = addr; b.be = be; b.we = we; b.wdata = wdata;
    exp_beats.push_back(b);
  endtask

  task automatic pushResp(input logic [31:0] rdata, input logic err);
    rsp_data.push_back(rdata);
    rsp_err.push_back(err);
  endtask

  task automatic pushDone(input logic is_load, input logic chk_data, input logic [31:0] rdata,
                          input logic err, input logic mis);
    done_t d;
    d.is_load = is_load; d.chk_data = chk_data; d.rdata = rdata; d.err = err; d.mis = mis;
    exp_done.push_back(d);
  endtask

  // Bus responder: checks every requesting cycle against the expected beat, grants after
  // gnt_dly waiting cycles and returns rvalid rv_dly cycles after the grant.
  initial begin
    int wait_cnt;
    int rv_cnt;
    beat_t b;
    wait_cnt = 0;
    rv_cnt = -1;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'h0;
      if (!rst_n) begin
        wait_cnt = 0;
        rv_cnt = -1;
      end else begin
        if (rv_cnt == 0) begin
          data_rvalid_i = 1'b1;
          if (rsp_data.size() > 0) begin
            data_rdata_i = rsp_data.pop_front();
            data_err_i   = rsp_err.pop_front();
          end else begin
            n_vec++; n_fail++;
            $display("[TB] FAIL bus_resp: no response queued for granted beat");
          end
          rv_cnt = -1;
        end else if (rv_cnt > 0) begin
          rv_cnt--;
        end
        #1;
        if (data_req_o) begin
          if (exp_beats.size() == 0) begin
            n_vec++; n_fail++;
            $display("[TB] FAIL bus_beat: unexpected request addr 0x%08h, expected none", data_addr_o);
          end else begin
            b = exp_beats[0];
            checkOutput("bus_addr", data_addr_o, b.addr);
            checkOutput("bus_be", {28'h0, data_be_o}, {28'h0, b.be});
            checkOutput("bus_we", {31'h0, data_we_o}, {31'h0, b.we});
            checkOutput("bus_wdata", data_wdata_o, b.wdata);
          end
          if (wait_cnt >= gnt_dly) begin
            data_gnt_i = 1'b1;
            wait_cnt = 0;
            rv_cnt = rv_dly;
            grant_count++;
            if (exp_beats.size() > 0) void'(exp_beats.pop_front());
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // Completion monitor: an LSU completion is ready while the FSM is still busy.
  initial begin
    done_t d;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (busy_o && lsu_ready_ex_o) begin
          if (exp_done.size() == 0) begin
            n_vec++; n_fail++;
            $display("[TB] FAIL completion: unexpected ready while busy, expected none");
          end else begin
            d = exp_done.pop_front();
            checkOutput("load_err", {31'h0, load_err_o}, {31'h0, d.is_load & d.err});
            checkOutput("store_err", {31'h0, store_err_o}, {31'h0, ~d.is_load & d.err});
            checkOutput("misaligned", {31'h0, data_misaligned_o}, {31'h0, d.mis});
            if (d.chk_data) checkOutput("rdata_ex", data_rdata_ex_o, d.rdata);
          end
        end else if (load_err_o || store_err_o) begin
          n_vec++; n_fail++;
          $display("[TB] FAIL err_pulse: got load_err=%0b store_err=%0b outside completion, expected 0",
                   load_err_o, store_err_o);
        end
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [1:0] dtype, input logic sign,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int cyc;
    bit done;
    @(negedge clk);
    data_we_ex_i = we;
    data_type_ex_i = dtype;
    data_sign_ext_ex_i = sign;
    adder_result_ex_i = addr;
    data_wdata_ex_i = wdata;
    data_req_ex_i = 1'b1;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < 60) begin
      @(negedge clk);
      #2;
      cyc++;
      if (busy_o && lsu_ready_ex_o) done = 1'b1;
    end
    if (!done) begin
      n_vec++; n_fail++;
      $display("[TB] FAIL timeout: access at 0x%08h got no completion, expected one within 60 cycles", addr);
      data_req_ex_i = 1'b0;
      exp_beats.delete(); exp_done.delete(); rsp_data.delete(); rsp_err.delete();
    end else begin
      @(posedge clk);
      #1;
      data_req_ex_i = 1'b0;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req"}, {31'h0, data_req_o}, 32'h0);
    checkOutput({tag, "_addr"}, data_addr_o, 32'h0);
    checkOutput({tag, "_be"}, {28'h0, data_be_o}, 32'h0);
    checkOutput({tag, "_we"}, {31'h0, data_we_o}, 32'h0);
    checkOutput({tag, "_wdata"}, data_wdata_o, 32'h0);
    checkOutput({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
    checkOutput({tag, "_mis"}, {31'h0, data_misaligned_o}, 32'h0);
    checkOutput({tag, "_lerr"}, {31'h0, load_err_o}, 32'h0);
    checkOutput({tag, "_serr"}, {31'h0, store_err_o}, 32'h0);
    checkOutput({tag, "_rdata"}, data_rdata_ex_o, 32'h0);
    checkOutput({tag, "_ready"}, {31'h0, lsu_ready_ex_o}, 32'h1);
  endtask

  initial begin
    int start;
    int cyc;
    rst_n = 1'b0;
    data_req_ex_i = 1'b0; data_we_ex_i = 1'b0; data_type_ex_i = 2'b00;
    data_sign_ext_ex_i = 1'b0; adder_result_ex_i = 32'h0; data_wdata_ex_i = 32'h0;
    repeat (3) @(negedge clk);
    #2;
    checkResetOutputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned LW, gnt same cycle, rvalid next
    pushBeat(32'h100, 4'b1111, 1'b0, 32'h0);
    pushResp(32'hDEADBEEF, 1'b0);
    pushDone(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h100, 32'h0);

    // LB at 0x103 signed, then unsigned
    pushBeat(32'h100, 4'b1000, 1'b0, 32'h0);
    pushResp(32'h80000000, 1'b0);
    pushDone(1'b1, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b1, 32'h103, 32'h0);
    pushBeat(32'h100, 4'b1000, 1'b0, 32'h0);
    pushResp(32'h80000000, 1'b0);
    pushDone(1'b1, 1'b1, 32'h00000080, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h103, 32'h0);

    // Misaligned LW at 0x102
    pushBeat(32'h100, 4'b1100, 1'b0, 32'h0);
    pushBeat(32'h104, 4'b0011, 1'b0, 32'h0);
    pushResp(32'h11223344, 1'b0);
    pushResp(32'h55667788, 1'b0);
    pushDone(1'b1, 1'b1, 32'h77881122, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h102, 32'h0);

    // Misaligned SH at 0x0FF with delayed grants
    gnt_dly = 3;
    pushBeat(32'h0FC, 4'b1000, 1'b1, 32'hCD0000AB);
    pushBeat(32'h100, 4'b0001, 1'b1, 32'hCD0000AB);
    pushResp(32'h0, 1'b0);
    pushResp(32'h0, 1'b0);
    pushDone(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h0FF, 32'h0000ABCD);
    gnt_dly = 0;

    // Aligned signed LH at offset 2
    pushBeat(32'h100, 4'b1100, 1'b0, 32'h0);
    pushResp(32'h80010000, 1'b0);
    pushDone(1'b1, 1'b1, 32'hFFFF8001, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h102, 32'h0);

    // Misaligned LW wrapping past the top of the address space
    pushBeat(32'hFFFFFFFC, 4'b1110, 1'b0, 32'h0);
    pushBeat(32'h00000000, 4'b0001, 1'b0, 32'h0);
    pushResp(32'hAABBCCDD, 1'b0);
    pushResp(32'h11223344, 1'b0);
    pushDone(1'b1, 1'b1, 32'h44AABBCC, 1'b0, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'hFFFFFFFD, 32'h0);

    // Type 11 behaves as a word
    pushBeat(32'h200, 4'b1111, 1'b0, 32'h0);
    pushResp(32'h12345678, 1'b0);
    pushDone(1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b11, 1'b1, 32'h200, 32'h0);

    // SB with bus error
    pushBeat(32'h300, 4'b0010, 1'b1, 32'h00005A00);
    pushResp(32'h0, 1'b1);
    pushDone(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h301, 32'h0000005A);

    // Misaligned LW with error on phase 1: no second beat
    pushBeat(32'h100, 4'b1110, 1'b0, 32'h0);
    pushResp(32'h0, 1'b1);
    pushDone(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h101, 32'h0);
    @(negedge clk);
    #2;
    checkOutput("idle_after_err", {31'h0, busy_o}, 32'h0);
    checkOutput("no_req_after_err", {31'h0, data_req_o}, 32'h0);

    // Reset while waiting for the phase-2 response
    rv_dly = 3;
    pushBeat(32'h200, 4'b1100, 1'b0, 32'h0);
    pushBeat(32'h204, 4'b0011, 1'b0, 32'h0);
    pushResp(32'h0, 1'b0);
    pushResp(32'h0, 1'b0);
    @(negedge clk);
    data_we_ex_i = 1'b0; data_type_ex_i = 2'b00; data_sign_ext_ex_i = 1'b0;
    adder_result_ex_i = 32'h202; data_wdata_ex_i = 32'h0;
    data_req_ex_i = 1'b1;
    start = grant_count;
    cyc = 0;
    while (grant_count < start + 2 && cyc < 60) begin
      @(posedge clk);
      cyc++;
    end
    if (grant_count < start + 2) begin
      n_vec++; n_fail++;
      $display("[TB] FAIL rst_setup: got %0d grants, expected 2", grant_count - start);
    end
    #2;
    checkOutput("mis_busy", {31'h0, busy_o}, 32'h1);
    checkOutput("mis_flag", {31'h0, data_misaligned_o}, 32'h1);
    #1;
    rst_n = 1'b0;
    data_req_ex_i = 1'b0;
    #1;
    checkResetOutputs("midrst");
    exp_beats.delete(); exp_done.delete(); rsp_data.delete(); rsp_err.delete();
    rv_dly = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Aligned SW after reset
    pushBeat(32'h300, 4'b1111, 1'b1, 32'hCAFEF00D);
    pushResp(32'h0, 1'b0);
    pushDone(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h300, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    checkOutput("beats_left", exp_beats.size(), 32'h0);
    checkOutput("done_left", exp_done.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
